// File: rtl/sram_loader.sv
// sram_loader: fills the 16-word operand SRAM one operator entry at a time,
// then zero-fills any words left over when the operator finishes early.
module sram_loader #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DEPTH      = 16
) (
  input  logic                  slow_clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  entry_valid,
  input  logic [DATA_WIDTH-1:0] entry_data,
  input  logic                  finish,
  output logic                  mem_writeEn,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_writeData,
  output logic                  busy,
  output logic                  load_done,
  output logic [ADDR_WIDTH:0]   word_count
);

  localparam int unsigned CNT_WIDTH = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_ENTRY,
    S_WRITE,
    S_CLEAR,
    S_DONE
  } state_t;

  state_t                  state, state_next;
  logic                    write_en_next;
  logic [ADDR_WIDTH-1:0]   address_next;
  logic [DATA_WIDTH-1:0]   write_data_next;
  logic                    busy_next;
  logic                    load_done_next;
  logic [CNT_WIDTH-1:0]    word_count_next;

  // State and registered outputs
  always_ff @(posedge slow_clock or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      mem_writeEn   <= 1'b0;
      mem_address   <= '0;
      mem_writeData <= '0;
      busy          <= 1'b0;
      load_done     <= 1'b0;
      word_count    <= '0;
    end else begin
      state         <= state_next;
      mem_writeEn   <= write_en_next;
      mem_address   <= address_next;
      mem_writeData <= write_data_next;
      busy          <= busy_next;
      load_done     <= load_done_next;
      word_count    <= word_count_next;
    end
  end

  // Next-state and next-output decode; every register holds unless changed
  always_comb begin
    state_next      = state;
    write_en_next   = 1'b0;
    address_next    = mem_address;
    write_data_next = mem_writeData;
    busy_next       = busy;
    load_done_next  = load_done;
    word_count_next = word_count;

    unique case (state)
      S_IDLE, S_DONE: begin
        // A new session may start from either resting state
        if (start) begin
          state_next      = S_WAIT_ENTRY;
          address_next    = '0;
          word_count_next = '0;
          busy_next       = 1'b1;
          load_done_next  = 1'b0;
        end
      end

      S_WAIT_ENTRY: begin
        // An entry beats a simultaneous finish; the finish is dropped
        if (entry_valid) begin
          state_next      = S_WRITE;
          write_data_next = entry_data;
          write_en_next   = 1'b1;
        end else if (finish) begin
          state_next      = S_CLEAR;
          write_data_next = '0;
          write_en_next   = 1'b1;
        end
      end

      S_WRITE: begin
        // Single-cycle write strobe; commit the count and move on
        word_count_next = word_count + CNT_WIDTH'(1);
        if (mem_address == LAST_ADDR) begin
          state_next     = S_DONE;
          busy_next      = 1'b0;
          load_done_next = 1'b1;
        end else begin
          address_next = mem_address + ADDR_WIDTH'(1);
          state_next   = S_WAIT_ENTRY;
        end
      end

      S_CLEAR: begin
        // Zero-fill sweeps to the last word with the strobe held high
        if (mem_address == LAST_ADDR) begin
          state_next     = S_DONE;
          busy_next      = 1'b0;
          load_done_next = 1'b1;
        end else begin
          address_next  = mem_address + ADDR_WIDTH'(1);
          write_en_next = 1'b1;
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_sram_loader.sv
// tb_sram_loader: scoreboard bench for sram_loader. Expected SRAM writes are
// queued as stimulus is driven and compared whenever the write strobe is high.
module tb_sram_loader;

  localparam int unsigned DW    = 16;
  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 16;

  logic          slow_clock = 1'b0;
  logic          reset;
  logic          start;
  logic          entry_valid;
  logic [DW-1:0] entry_data;
  logic          finish;
  logic          mem_writeEn;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_writeData;
  logic          busy;
  logic          load_done;
  logic [AW:0]   word_count;

  typedef struct {
    int unsigned  addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  int unsigned model_addr;
  int unsigned model_count;
  bit          model_done;

  sram_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .slow_clock    (slow_clock),
    .reset         (reset),
    .start         (start),
    .entry_valid   (entry_valid),
    .entry_data    (entry_data),
    .finish        (finish),
    .mem_writeEn   (mem_writeEn),
    .mem_address   (mem_address),
    .mem_writeData (mem_writeData),
    .busy          (busy),
    .load_done     (load_done),
    .word_count    (word_count)
  );

  always #5 slow_clock = ~slow_clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Every cycle with the strobe high is one SRAM write; match it to the queue
  always @(negedge slow_clock) begin
    if (mem_writeEn !== 1'b0) begin
      check_eq("we_only_while_busy", 32'(busy), 32'd1);
      if (sb.size() == 0) begin
        check_eq("write_was_expected", 32'(sb.size()), 32'd1);
      end else begin
        wr_t e;
        e = sb.pop_front();
        check_eq("write_addr", 32'(mem_address), 32'(e.addr));
        check_eq("write_data", 32'(mem_writeData), 32'(e.data));
      end
    end
  end

  task automatic start_session();
    @(negedge slow_clock) start = 1'b1;
    @(negedge slow_clock) start = 1'b0;
    model_addr  = 0;
    model_count = 0;
    model_done  = 1'b0;
    check_eq("start_busy", 32'(busy), 32'd1);
    check_eq("start_addr", 32'(mem_address), 32'd0);
    check_eq("start_count", 32'(word_count), 32'd0);
    check_eq("start_done_clear", 32'(load_done), 32'd0);
  endtask

  task automatic model_accept();
    model_count++;
    if (model_addr == DEPTH - 1) model_done = 1'b1;
    else model_addr++;
  endtask

  // One entry pulse (optionally colliding with finish) followed by idle cycles
  task automatic enter(input logic [DW-1:0] d, input bit with_finish);
    wr_t e;
    @(negedge slow_clock);
    entry_valid = 1'b1;
    entry_data  = d;
    finish      = with_finish;
    e.addr = model_addr;
    e.data = d;
    sb.push_back(e);
    @(negedge slow_clock);
    entry_valid = 1'b0;
    finish      = 1'b0;
    model_accept();
    @(negedge slow_clock);
    check_eq("we_single_cycle", 32'(mem_writeEn), 32'd0);
    check_eq("entry_count", 32'(word_count), 32'(model_count));
    check_eq("entry_done", 32'(load_done), 32'(model_done));
    check_eq("entry_addr", 32'(mem_address), 32'(model_addr));
    @(negedge slow_clock);
  endtask

  task automatic wait_done(input int unsigned exp_cycles);
    int unsigned cycles;
    cycles = 0;
    while (load_done !== 1'b1 && cycles < 40) begin
      @(negedge slow_clock);
      cycles++;
    end
    check_eq("cycles_to_done", 32'(cycles), 32'(exp_cycles));
  endtask

  task automatic do_finish();
    int unsigned first;
    wr_t e;
    first = model_addr;
    @(negedge slow_clock) finish = 1'b1;
    for (int unsigned a = first; a < DEPTH; a++) begin
      e.addr = a;
      e.data = '0;
      sb.push_back(e);
    end
    @(negedge slow_clock) finish = 1'b0;
    wait_done(DEPTH - first);
    model_done = 1'b1;
    model_addr = DEPTH - 1;
    check_eq("finish_count", 32'(word_count), 32'(model_count));
    check_eq("finish_addr", 32'(mem_address), 32'(DEPTH - 1));
    check_eq("finish_busy", 32'(busy), 32'd0);
    check_eq("finish_we", 32'(mem_writeEn), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_we"}, 32'(mem_writeEn), 32'd0);
    check_eq({tag, "_addr"}, 32'(mem_address), 32'd0);
    check_eq({tag, "_data"}, 32'(mem_writeData), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_done"}, 32'(load_done), 32'd0);
    check_eq({tag, "_count"}, 32'(word_count), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned guard;
    wr_t e;
    reset       = 1'b0;
    start       = 1'b0;
    entry_valid = 1'b0;
    finish      = 1'b0;
    entry_data  = '0;

    // Inputs toggled while held in reset must have no effect
    repeat (2) @(negedge slow_clock);
    start       = 1'b1;
    entry_valid = 1'b1;
    finish      = 1'b1;
    entry_data  = 16'hBEEF;
    @(negedge slow_clock);
    start       = 1'b0;
    entry_valid = 1'b0;
    finish      = 1'b0;
    check_all_zero("in_reset");
    @(negedge slow_clock) reset = 1'b1;
    repeat (2) @(negedge slow_clock);
    check_all_zero("after_reset");

    // Entry while idle: no write, no session
    @(negedge slow_clock);
    entry_valid = 1'b1;
    entry_data  = 16'h5555;
    @(negedge slow_clock) entry_valid = 1'b0;
    @(negedge slow_clock);
    check_eq("idle_entry_busy", 32'(busy), 32'd0);
    check_eq("idle_entry_count", 32'(word_count), 32'd0);

    // Full 16-word load, with a stray start mid-session
    start_session();
    for (int i = 0; i < 16; i++) begin
      enter(16'h3C00 + 16'(i), 1'b0);
      if (i == 1) begin
        @(negedge slow_clock) start = 1'b1;
        @(negedge slow_clock) start = 1'b0;
        @(negedge slow_clock);
        check_eq("restart_ignored_addr", 32'(mem_address), 32'd2);
        check_eq("restart_ignored_count", 32'(word_count), 32'd2);
        check_eq("restart_ignored_busy", 32'(busy), 32'd1);
      end
    end
    check_eq("full_count", 32'(word_count), 32'd16);
    check_eq("full_busy", 32'(busy), 32'd0);
    check_eq("full_addr", 32'(mem_address), 32'd15);
    check_eq("full_sb_empty", 32'(sb.size()), 32'd0);

    // Early finish after three words: zero-fill addresses 3..15
    start_session();
    enter(16'h4000, 1'b0);
    enter(16'h4200, 1'b0);
    enter(16'h4400, 1'b0);
    do_finish();
    check_eq("early_count", 32'(word_count), 32'd3);
    check_eq("early_sb_empty", 32'(sb.size()), 32'd0);

    // Entry and finish together: entry wins, finish dropped
    start_session();
    for (int i = 0; i < 5; i++) enter(16'h1000 + 16'(i), 1'b0);
    enter(16'h1234, 1'b1);
    repeat (3) @(negedge slow_clock);
    check_eq("collide_we", 32'(mem_writeEn), 32'd0);
    check_eq("collide_busy", 32'(busy), 32'd1);
    check_eq("collide_addr", 32'(mem_address), 32'd6);
    check_eq("collide_count", 32'(word_count), 32'd6);

    // Back-to-back entry pulses: the second lands in WRITE and is dropped
    @(negedge slow_clock);
    entry_valid = 1'b1;
    entry_data  = 16'hAAAA;
    e.addr = model_addr;
    e.data = 16'hAAAA;
    sb.push_back(e);
    @(negedge slow_clock) entry_data = 16'hBBBB;
    @(negedge slow_clock) entry_valid = 1'b0;
    model_accept();
    repeat (2) @(negedge slow_clock);
    check_eq("b2b_addr", 32'(mem_address), 32'd7);
    check_eq("b2b_count", 32'(word_count), 32'd7);
    check_eq("b2b_sb_empty", 32'(sb.size()), 32'd0);

    // Reset in the middle of the zero-fill sweep
    @(negedge slow_clock) finish = 1'b1;
    for (int unsigned a = model_addr; a < DEPTH; a++) begin
      e.addr = a;
      e.data = '0;
      sb.push_back(e);
    end
    @(negedge slow_clock) finish = 1'b0;
    guard = 0;
    while (mem_address !== 4'd9 && guard < 40) begin
      @(negedge slow_clock);
      guard++;
    end
    check_eq("clear_reached_9", 32'(mem_address), 32'd9);
    #2 reset = 1'b0;
    #1 check_all_zero("mid_clear_reset");
    sb.delete();
    @(negedge slow_clock);
    @(negedge slow_clock) reset = 1'b1;
    @(negedge slow_clock);
    check_all_zero("post_abort_idle");

    // A new session restarts from address 0
    start_session();
    enter(16'h7777, 1'b0);
    do_finish();
    check_eq("restart_count", 32'(word_count), 32'd1);
    repeat (2) @(negedge slow_clock);
    check_eq("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_loader.md
Name: sram_loader

Overview:
- Write-side companion to the FPMAC datapath's SRAM read path; fills the 16-word operand SRAM before an accumulate run.
- Accepts operand words one at a time: a data bus from board switches, qualified by the debounced push-button pulse.
- Drives the SRAM write port sequentially from address 0. If the operator finishes early, zero-fills the remaining words so a full-depth MAC run adds nothing spurious.
- Sits beside the existing controller FSM, in the slow_clock domain.

Parameters:
- DATA_WIDTH, 16, SRAM word width.
- ADDR_WIDTH, 4, SRAM address width.
- DEPTH, 16, number of words to fill; must equal 2**ADDR_WIDTH.

Ports:
- slow_clock  input  1  system slow clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; begins a load session.
- entry_valid  input  1  one-cycle pulse from the push-button validator; entry_data is valid.
- entry_data  input  DATA_WIDTH  operand word to store.
- finish  input  1  one-cycle pulse; ends user entry early and triggers the zero-fill.
- mem_writeEn  output  1  SRAM write enable, registered.
- mem_address  output  ADDR_WIDTH  SRAM address, registered.
- mem_writeData  output  DATA_WIDTH  SRAM write data, registered.
- busy  output  1  high from start acceptance until the DONE state.
- load_done  output  1  high while in DONE.
- word_count  output  ADDR_WIDTH+1  number of user-supplied words written (0..DEPTH).

Behaviour:
- Reset (async, active-low): state=IDLE, mem_writeEn=0, mem_address=0, mem_writeData=0, busy=0, load_done=0, word_count=0. Reset mid-session aborts immediately; SRAM contents already written are left untouched.
- All outputs are registered. No combinational path runs from any input to any output.
- IDLE:
  - start -> WAIT_ENTRY; mem_address=0, word_count=0, busy=1.
  - entry_valid and finish are ignored.
- WAIT_ENTRY:
  - entry_valid sampled at edge N -> mem_writeData=entry_data, mem_writeEn=1, state=WRITE, all effective after edge N. The SRAM commits at edge N+1.
  - finish (without entry_valid) -> state=CLEAR; mem_writeData=0, mem_writeEn=1 at the current mem_address.
  - entry_valid and finish in the same cycle: the entry wins and finish is dropped; the operator must re-press finish.
  - start is ignored.
- WRITE (exactly one cycle):
  - mem_writeEn drops to 0 at the next edge; word_count increments.
  - If mem_address==DEPTH-1 -> DONE; otherwise mem_address increments and the state returns to WAIT_ENTRY.
  - entry_valid and finish are ignored in this cycle.
- CLEAR:
  - Writes 0 to one address per cycle, mem_writeEn held continuously high, mem_address incrementing each cycle.
  - The write to DEPTH-1 is the last; at the following edge mem_writeEn=0 and state=DONE.
  - word_count does not change. All inputs are ignored.
  - Zero-fill write count = DEPTH - word_count.
- DONE:
  - busy=0, load_done=1, mem_writeEn=0; mem_address holds DEPTH-1.
  - start -> new session, as from IDLE; load_done clears.
  - entry_valid and finish are ignored.
- Address wrap: mem_address never increments past DEPTH-1. There is no wrap to 0 within a session.
- finish when word_count==DEPTH is unreachable, because the state is already DONE.
- word_count saturates at DEPTH by construction. Width is ADDR_WIDTH+1 so that 16 is representable.
- Exactly one SRAM write occurs per accepted entry. mem_writeEn is never high in IDLE or DONE.

Test Plan:
- Reset values: hold reset low, pulse start/entry_valid/finish -> all outputs 0, state IDLE. Release reset -> still idle.
- Full load: start, then 16 entries of 0x3C00+i, each separated by >=2 idle cycles -> 16 single-cycle writes at addresses 0..15 with matching data; word_count=16; load_done=1 one cycle after the last write.
- Early finish: start, entries 0x4000, 0x4200, 0x4400, then finish -> writes at addresses 0..2, then 13 consecutive zero writes at addresses 3..15; word_count=3; DONE.
- Collision and ignore rules:
  - entry_valid+finish together with data 0x1234 at address 5 -> only 0x1234 written to address 5; state WAIT_ENTRY at address 6.
  - entry_valid during IDLE -> no write.
  - start while busy -> no effect.
- Back-to-back entry: entry_valid on two consecutive cycles -> second pulse lands in WRITE and is dropped; exactly one write.
- Reset mid-CLEAR: assert reset at address 9 -> mem_writeEn=0 asynchronously; all outputs return to reset values. A following start restarts at address 0.
